// File: rtl/mux_sched_pkg.sv
// rtl/mux_sched_pkg.sv - shared types and constants for the round-robin mux scheduler
package mux_sched_pkg;

  localparam int NUM_REQ = 4;
  localparam int SLOT_W  = 4;

  // Starting from 3 makes requester 0 the first winner after reset.
  localparam logic [1:0] LAST_RST = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [1:0] idx);
    onehot = NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux_sched_if.sv
// rtl/mux_sched_if.sv - tile pin bundle shared by the scheduler and its driver
interface mux_sched_if;

  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport slave (
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );

  modport master (
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

endinterface

// File: rtl/mux_sched_rr_pick.sv
// rtl/mux_sched_rr_pick.sv - combinational round-robin picker starting after the last winner
module mux_sched_rr_pick
  import mux_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  output logic [1:0]         winner,
  output logic               any
);

  logic [1:0] idx;

  // The previous winner is visited last, so it only wins when nobody else asks.
  always_comb begin
    winner = last;
    any    = 1'b0;
    idx    = last;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = last + 2'(k);
      if (!any && req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tt_um_safana_mux_sched.sv
// rtl/tt_um_safana_mux_sched.sv - scheduler FSM, slot counter and output registers
// Optional MUX_SCHED_PRIO_EN: requester 0 gets strict priority over the rotating 1..3.
module tt_um_safana_mux_sched
  import mux_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  mux_sched_if.slave  pins
);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] dat;
  logic [SLOT_W-1:0]  slot_len;
  logic               unused_uio;

  assign req        = pins.ui_in[3:0];
  assign dat        = pins.ui_in[7:4];
  assign slot_len   = pins.uio_in[3:0];
  assign unused_uio = &{1'b0, pins.uio_in[7:4]};

  state_t             state, state_n;
  logic [NUM_REQ-1:0] gnt, gnt_n;
  logic [1:0]         sel, sel_n;
  logic               dout, dout_n;
  logic               busy, busy_n;
  logic [SLOT_W-1:0]  slot_cnt, cnt_n;
  logic [1:0]         last, last_n;

  logic [1:0]         winner;
  logic               any;

`ifdef MUX_SCHED_PRIO_EN
  logic [1:0] rr_winner;
  logic       rr_any;

  // Requester 0 is masked out of the rotation and overrides it when asserted.
  mux_sched_rr_pick u_pick (
    .req    ({req[3:1], 1'b0}),
    .last   (last),
    .winner (rr_winner),
    .any    (rr_any)
  );

  assign winner = req[0] ? 2'd0 : rr_winner;
  assign any    = req[0] | rr_any;
`else
  mux_sched_rr_pick u_pick (
    .req    (req),
    .last   (last),
    .winner (winner),
    .any    (any)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      sel      <= '0;
      dout     <= 1'b0;
      busy     <= 1'b0;
      slot_cnt <= '0;
      last     <= LAST_RST;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      sel      <= sel_n;
      dout     <= dout_n;
      busy     <= busy_n;
      slot_cnt <= cnt_n;
      last     <= last_n;
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    sel_n   = sel;
    dout_n  = dout;
    busy_n  = busy;
    cnt_n   = slot_cnt;
    last_n  = last;

    if (!ena) begin
      state_n = IDLE;
      gnt_n   = '0;
      dout_n  = 1'b0;
      busy_n  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          gnt_n  = '0;
          dout_n = 1'b0;
          busy_n = 1'b0;
          if (any) begin
            state_n = GRANT;
            gnt_n   = onehot(winner);
            sel_n   = winner;
            last_n  = winner;
            cnt_n   = slot_len;
            busy_n  = 1'b1;
            dout_n  = dat[winner];
          end
        end
        GRANT: begin
          busy_n = 1'b1;
          if (slot_cnt == '0 || !req[sel]) begin
            state_n = RELEASE;
            gnt_n   = '0;
            dout_n  = 1'b0;
            cnt_n   = '0;
          end else begin
            dout_n = dat[sel];
            cnt_n  = slot_cnt - SLOT_W'(1);
          end
        end
        RELEASE: begin
          state_n = IDLE;
          gnt_n   = '0;
          dout_n  = 1'b0;
          busy_n  = 1'b0;
        end
        default: begin
          state_n = IDLE;
          gnt_n   = '0;
          dout_n  = 1'b0;
          busy_n  = 1'b0;
        end
      endcase
    end
  end

  assign pins.uo_out  = {busy, dout, sel, gnt};
  assign pins.uio_out = 8'h00;
  assign pins.uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_safana_mux_sched.sv
// tb/tb_tt_um_safana_mux_sched.sv - self-checking bench for the round-robin mux scheduler
module tb_tt_um_safana_mux_sched;

  logic clk;
  logic rst_n;
  logic ena;
  int   total;
  int   bad;
  int   mlast;
  int   w;
  logic d;

  mux_sched_if pins();

  tt_um_safana_mux_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .pins  (pins)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin reference: scan (last+1..last+4) mod 4, optional strict priority for 0.
  function automatic int model_pick(input logic [3:0] r, input int lst);
`ifdef MUX_SCHED_PRIO_EN
    if (r[0]) return 0;
`endif
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (lst + k) % 4;
`ifdef MUX_SCHED_PRIO_EN
      if (c == 0) continue;
`endif
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    mlast = 3;
  endtask

  // Waits for a grant, checks who got it, the idle gap before it, its length and its data path.
  task automatic grab(input int ei, input int elen, input int egap);
    int   n;
    int   len;
    logic ed;
    n = 0;
    while (pins.uo_out[3:0] == 4'b0 && n < 40) begin
      tick();
      n++;
    end
    chk("grant_onehot", 32'(pins.uo_out[3:0]), 32'(1) << ei);
    chk("grant_sel", 32'(pins.uo_out[5:4]), ei);
    if (egap >= 0) chk("grant_gap", n, egap);
    ed  = pins.ui_in[4+ei];
    len = 0;
    while (pins.uo_out[3:0] == (4'b0001 << ei) && len < 40) begin
      chk("grant_dout", 32'(pins.uo_out[6]), 32'(ed));
      pins.ui_in[7:4] = 4'($urandom);
      ed = pins.ui_in[4+ei];
      len++;
      tick();
    end
    chk("grant_len", len, elen);
    chk("release_busy", 32'(pins.uo_out[7]), 1);
    chk("release_dout", 32'(pins.uo_out[6]), 0);
  endtask

  initial begin
    logic [3:0] r;
    int         s;
    total = 0;
    bad   = 0;
    mlast = 3;
    rst_n = 1'b0;
    ena   = 1'b1;
    pins.ui_in  = 8'h00;
    pins.uio_in = 8'h00;
    tick();
    tick();
    chk("reset_uo_out", 32'(pins.uo_out), 0);
    chk("reset_uio_out", 32'(pins.uio_out), 0);
    chk("reset_uio_oe", 32'(pins.uio_oe), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_uo_out", 32'(pins.uo_out), 0);

    // Single requester, slot_len=3: four grant cycles, one release cycle, then idle.
    pins.ui_in  = 8'b0000_0001;
    pins.uio_in = 8'h03;
    w = model_pick(4'b0001, mlast);
    mlast = w;
    grab(w, 4, 1);
    pins.ui_in = 8'h00;
    tick();
    chk("after_release_idle", 32'(pins.uo_out[7]), 0);
    chk("after_release_gnt", 32'(pins.uo_out[3:0]), 0);

    // All requesting, slot_len=0: one-cycle grants rotating with two-cycle gaps.
    do_reset();
    pins.ui_in  = 8'b0000_1111;
    pins.uio_in = 8'h00;
    for (int i = 0; i < 5; i++) begin
      w = model_pick(4'b1111, mlast);
      mlast = w;
      grab(w, 1, (i == 0) ? 1 : 2);
    end
    pins.ui_in = 8'h00;
    tick();
    tick();

    do_reset();
    pins.ui_in = 8'b0000_1110;
    for (int i = 0; i < 4; i++) begin
      w = model_pick(4'b1110, mlast);
      mlast = w;
      grab(w, 1, (i == 0) ? 1 : 2);
    end
    pins.ui_in = 8'h00;
    tick();
    tick();

    // Early release after 5 cycles with toggling data; slot_len change mid-grant is ignored.
    pins.uio_in = 8'h0F;
    pins.ui_in  = 8'b0100_0100;
    w = model_pick(4'b0100, mlast);
    mlast = w;
    d = 1'b1;
    tick();
    for (int i = 1; i <= 5; i++) begin
      chk("early_gnt", 32'(pins.uo_out[3:0]), 32'(1) << w);
      chk("early_dout", 32'(pins.uo_out[6]), 32'(d));
      d = ~d;
      pins.ui_in[6] = d;
      if (i == 2) pins.uio_in = 8'h00;
      if (i == 5) pins.ui_in[2] = 1'b0;
      tick();
    end
    chk("early_release_gnt", 32'(pins.uo_out[3:0]), 0);
    chk("early_release_busy", 32'(pins.uo_out[7]), 1);
    chk("early_release_dout", 32'(pins.uo_out[6]), 0);
    tick();
    chk("early_idle_busy", 32'(pins.uo_out[7]), 0);

    // ena low mid-grant clears outputs; last is kept for the next arbitration.
    pins.ui_in  = 8'b0000_0010;
    pins.uio_in = 8'h07;
    w = model_pick(4'b0010, mlast);
    mlast = w;
    tick();
    chk("ena_pre_gnt", 32'(pins.uo_out[3:0]), 32'(1) << w);
    tick();
    ena = 1'b0;
    tick();
    chk("ena_low_gnt", 32'(pins.uo_out[3:0]), 0);
    chk("ena_low_busy", 32'(pins.uo_out[7]), 0);
    chk("ena_low_dout", 32'(pins.uo_out[6]), 0);
    ena = 1'b1;
    pins.ui_in = 8'b0000_1010;
    w = model_pick(4'b1010, mlast);
    mlast = w;
    tick();
    chk("ena_regrant_gnt", 32'(pins.uo_out[3:0]), 32'(1) << w);
    tick();

    // Asynchronous reset mid-grant, then requester 0 wins first.
    rst_n = 1'b0;
    #1;
    chk("async_reset_uo_out", 32'(pins.uo_out), 0);
    tick();
    rst_n = 1'b1;
    mlast = 3;
    pins.ui_in = 8'b0000_1111;
    w = model_pick(4'b1111, mlast);
    mlast = w;
    tick();
    chk("post_reset_gnt", 32'(pins.uo_out[3:0]), 32'(1) << w);
    pins.ui_in = 8'h00;
    tick();
    tick();
    tick();
    chk("post_reset_idle", 32'(pins.uo_out[7]), 0);

    // Random request patterns, slot lengths, data and unused uio bits.
    for (int t = 0; t < 16; t++) begin
      r = 4'($urandom_range(1, 15));
      s = $urandom_range(0, 3);
      pins.ui_in  = {4'($urandom), r};
      pins.uio_in = {4'($urandom), 4'(s)};
      w = model_pick(r, mlast);
      mlast = w;
      grab(w, s + 1, 1);
      pins.ui_in[3:0] = 4'b0000;
      tick();
      chk("rand_idle_uo_out", 32'(pins.uo_out[3:0]), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
